// File: rtl/lemming_monitor.sv
// Passive observer for the lemming behaviour FSM: tracks position, falls, turns and
// dig time from the one-hot status lines, and latches death and protocol faults.
module lemming_monitor #(
  parameter int POS_W = 8,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    areset,
  input  logic                    walk_left,
  input  logic                    walk_right,
  input  logic                    aaah,
  input  logic                    digging,
  output logic signed [POS_W-1:0] pos,
  output logic [CNT_W-1:0]        fall_len,
  output logic [CNT_W-1:0]        max_fall,
  output logic [CNT_W-1:0]        turn_count,
  output logic [CNT_W-1:0]        dig_cycles,
  output logic                    land_pulse,
  output logic                    splat_pulse,
  output logic                    turn_pulse,
  output logic                    dead,
  output logic                    fault
);

  typedef enum logic [2:0] {ST_WALK, ST_FALL, ST_DIG, ST_DEAD, ST_FAULT} state_t;
  typedef enum logic [2:0] {C_L, C_R, C_F, C_D, C_Z, C_M} sample_t;
  typedef enum logic {DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1} dir_t;

  localparam logic signed [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
  localparam logic signed [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};
  localparam logic signed [POS_W-1:0] POS_ONE = POS_W'(1);
  localparam logic [CNT_W-1:0]        CNT_ONE = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  state_t                    state, state_nxt;
  sample_t                   cls;
  dir_t                      last_dir, last_dir_nxt;
  logic [CNT_W-1:0]          fall_ctr, fall_ctr_nxt;
  logic [CNT_W-1:0]          fall_len_nxt, max_fall_nxt, turn_count_nxt, dig_cycles_nxt;
  logic signed [POS_W-1:0]   pos_nxt;
  logic                      land_nxt, splat_nxt, turn_nxt, dead_nxt, fault_nxt;
  logic                      walk_step;

  always_comb begin
    case ({walk_left, walk_right, aaah, digging})
      4'b1000: cls = C_L;
      4'b0100: cls = C_R;
      4'b0010: cls = C_F;
      4'b0001: cls = C_D;
      4'b0000: cls = C_Z;
      default: cls = C_M;
    endcase
  end

  always_comb begin
    // NOTE: every value written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_nxt      = state;
    pos_nxt        = pos;
    fall_ctr_nxt   = fall_ctr;
    fall_len_nxt   = fall_len;
    max_fall_nxt   = max_fall;
    turn_count_nxt = turn_count;
    dig_cycles_nxt = dig_cycles;
    last_dir_nxt   = last_dir;
    land_nxt       = 1'b0;
    splat_nxt      = 1'b0;
    turn_nxt       = 1'b0;
    dead_nxt       = dead;
    fault_nxt      = fault;
    walk_step      = 1'b0;

    case (state)
      ST_WALK: begin
        case (cls)
          C_L, C_R: walk_step = 1'b1;
          C_F: begin
            state_nxt    = ST_FALL;
            fall_ctr_nxt = CNT_ONE;
          end
          C_D: begin
            state_nxt      = ST_DIG;
            dig_cycles_nxt = sat_inc(dig_cycles);
          end
          C_Z: begin
            state_nxt = ST_DEAD;
            dead_nxt  = 1'b1;
          end
          default: begin
            state_nxt = ST_FAULT;
            fault_nxt = 1'b1;
          end
        endcase
      end
      ST_FALL: begin
        case (cls)
          C_F: fall_ctr_nxt = sat_inc(fall_ctr);
          C_L, C_R: begin
            state_nxt    = ST_WALK;
            walk_step    = 1'b1;
            land_nxt     = 1'b1;
            fall_len_nxt = fall_ctr;
            max_fall_nxt = (fall_ctr > max_fall) ? fall_ctr : max_fall;
          end
          C_Z: begin
            state_nxt    = ST_DEAD;
            dead_nxt     = 1'b1;
            splat_nxt    = 1'b1;
            fall_len_nxt = fall_ctr;
          end
          default: begin
            state_nxt = ST_FAULT;
            fault_nxt = 1'b1;
          end
        endcase
      end
      ST_DIG: begin
        case (cls)
          C_D: dig_cycles_nxt = sat_inc(dig_cycles);
          C_F: begin
            state_nxt    = ST_FALL;
            fall_ctr_nxt = CNT_ONE;
          end
          C_Z: begin
            state_nxt = ST_DEAD;
            dead_nxt  = 1'b1;
          end
          default: begin
            // A dig can only end in a fall or a death; walking out of it is illegal.
            state_nxt = ST_FAULT;
            fault_nxt = 1'b1;
          end
        endcase
      end
      default: ;
    endcase

    // Walking samples (including the landing one) move the lemming and may reverse it.
    if (walk_step) begin
      last_dir_nxt = (cls == C_R) ? DIR_RIGHT : DIR_LEFT;
      if (last_dir_nxt != last_dir) begin
        turn_nxt       = 1'b1;
        turn_count_nxt = sat_inc(turn_count);
      end
      if (cls == C_R) pos_nxt = (pos == POS_MAX) ? pos : pos + POS_ONE;
      else            pos_nxt = (pos == POS_MIN) ? pos : pos - POS_ONE;
    end
  end

  // NOTE: registers use non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state       <= ST_WALK;
      pos         <= '0;
      fall_ctr    <= '0;
      fall_len    <= '0;
      max_fall    <= '0;
      turn_count  <= '0;
      dig_cycles  <= '0;
      last_dir    <= DIR_LEFT;
      land_pulse  <= 1'b0;
      splat_pulse <= 1'b0;
      turn_pulse  <= 1'b0;
      dead        <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_nxt;
      pos         <= pos_nxt;
      fall_ctr    <= fall_ctr_nxt;
      fall_len    <= fall_len_nxt;
      max_fall    <= max_fall_nxt;
      turn_count  <= turn_count_nxt;
      dig_cycles  <= dig_cycles_nxt;
      last_dir    <= last_dir_nxt;
      land_pulse  <= land_nxt;
      splat_pulse <= splat_nxt;
      turn_pulse  <= turn_nxt;
      dead        <= dead_nxt;
      fault       <= fault_nxt;
    end
  end

endmodule

// File: tb/tb_lemming_monitor.sv
// Self-checking bench for lemming_monitor: directed vector table, corner-case
// sequences and a randomized run against an integer reference model.
module tb_lemming_monitor;

  localparam int POS_W   = 8;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int POS_HI  = (1 << (POS_W - 1)) - 1;
  localparam int POS_LO  = -(1 << (POS_W - 1));

  localparam logic [3:0] S_L = 4'b1000;
  localparam logic [3:0] S_R = 4'b0100;
  localparam logic [3:0] S_F = 4'b0010;
  localparam logic [3:0] S_D = 4'b0001;
  localparam logic [3:0] S_Z = 4'b0000;

  localparam int M_WALK = 0, M_FALL = 1, M_DIG = 2, M_DEAD = 3, M_FAULT = 4;

  logic                    clk = 1'b0;
  logic                    areset;
  logic [3:0]              smp = 4'b0;
  logic signed [POS_W-1:0] pos;
  logic [CNT_W-1:0]        fall_len, max_fall, turn_count, dig_cycles;
  logic                    land_pulse, splat_pulse, turn_pulse, dead, fault;

  int n_vec = 0;
  int n_err = 0;

  lemming_monitor #(.POS_W(POS_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .areset     (areset),
    .walk_left  (smp[3]),
    .walk_right (smp[2]),
    .aaah       (smp[1]),
    .digging    (smp[0]),
    .pos        (pos),
    .fall_len   (fall_len),
    .max_fall   (max_fall),
    .turn_count (turn_count),
    .dig_cycles (dig_cycles),
    .land_pulse (land_pulse),
    .splat_pulse(splat_pulse),
    .turn_pulse (turn_pulse),
    .dead       (dead),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  // Reference model: plain integers with clamping, driven by the sample rules.
  int m_mode, m_pos, m_fall, m_fall_len, m_max_fall, m_turns, m_digs;
  bit m_right, m_land, m_splat, m_turn;

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic model_reset();
    m_mode = M_WALK; m_pos = 0; m_fall = 0; m_fall_len = 0; m_max_fall = 0;
    m_turns = 0; m_digs = 0; m_right = 1'b0;
    m_land = 1'b0; m_splat = 1'b0; m_turn = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] s);
    bit moved;
    moved = 1'b0;
    m_land = 1'b0; m_splat = 1'b0; m_turn = 1'b0;
    if (m_mode == M_DEAD || m_mode == M_FAULT) return;
    if ($countones(s) > 1) begin
      m_mode = M_FAULT;
      return;
    end
    case (m_mode)
      M_WALK:
        if (s == S_L || s == S_R) moved = 1'b1;
        else if (s == S_F) begin m_mode = M_FALL; m_fall = 1; end
        else if (s == S_D) begin m_mode = M_DIG; m_digs = clamp(m_digs + 1, 0, CNT_MAX); end
        else m_mode = M_DEAD;
      M_FALL:
        if (s == S_F) m_fall = clamp(m_fall + 1, 0, CNT_MAX);
        else if (s == S_L || s == S_R) begin
          m_mode = M_WALK; moved = 1'b1; m_land = 1'b1;
          m_fall_len = m_fall;
          if (m_fall > m_max_fall) m_max_fall = m_fall;
        end
        else if (s == S_Z) begin m_mode = M_DEAD; m_splat = 1'b1; m_fall_len = m_fall; end
        else m_mode = M_FAULT;
      M_DIG:
        if (s == S_D) m_digs = clamp(m_digs + 1, 0, CNT_MAX);
        else if (s == S_F) begin m_mode = M_FALL; m_fall = 1; end
        else if (s == S_Z) m_mode = M_DEAD;
        else m_mode = M_FAULT;
      default: ;
    endcase
    if (moved) begin
      m_pos = clamp(m_pos + ((s == S_R) ? 1 : -1), POS_LO, POS_HI);
      if ((s == S_R) != m_right) begin
        m_turn  = 1'b1;
        m_turns = clamp(m_turns + 1, 0, CNT_MAX);
      end
      m_right = (s == S_R);
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("pos",         int'(pos),         m_pos);
    check("fall_len",    int'(fall_len),    m_fall_len);
    check("max_fall",    int'(max_fall),    m_max_fall);
    check("turn_count",  int'(turn_count),  m_turns);
    check("dig_cycles",  int'(dig_cycles),  m_digs);
    check("land_pulse",  int'(land_pulse),  int'(m_land));
    check("splat_pulse", int'(splat_pulse), int'(m_splat));
    check("turn_pulse",  int'(turn_pulse),  int'(m_turn));
    check("dead",        int'(dead),        int'(m_mode == M_DEAD));
    check("fault",       int'(fault),       int'(m_mode == M_FAULT));
  endtask

  // Drive one sample, let it be taken at the next rising edge, compare 1 time unit later.
  task automatic apply(input logic [3:0] s);
    smp = s;
    @(posedge clk);
    model_step(s);
    #1;
    compare_all();
  endtask

  task automatic apply_n(input logic [3:0] s, input int n);
    for (int i = 0; i < n; i++) apply(s);
  endtask

  // Asynchronous reset pulse placed between clock edges; outputs must clear before any edge.
  task automatic do_reset();
    areset = 1'b1;
    #2;
    model_reset();
    compare_all();
    areset = 1'b0;
  endtask

  typedef struct {
    logic [3:0] smp;
    int         pos;
    int         turns;
    bit         tp;
  } vec_t;

  vec_t t1 [10];
  logic [3:0] prev_s;

  function automatic logic [3:0] rand_sample(input logic [3:0] prev);
    int r;
    logic [3:0] m;
    if ($urandom_range(0, 99) < 65) return prev;
    r = $urandom_range(0, 99);
    if (r < 26) return S_L;
    if (r < 52) return S_R;
    if (r < 78) return S_F;
    if (r < 96) return S_D;
    if (r < 98) return S_Z;
    do m = 4'($urandom_range(0, 15)); while ($countones(m) < 2);
    return m;
  endfunction

  initial begin
    int tp_seen;
    int land_seen;

    t1[0] = '{S_L, -1, 0, 1'b0};
    t1[1] = '{S_L, -2, 0, 1'b0};
    t1[2] = '{S_L, -3, 0, 1'b0};
    t1[3] = '{S_L, -4, 0, 1'b0};
    t1[4] = '{S_L, -5, 0, 1'b0};
    t1[5] = '{S_R, -4, 1, 1'b1};
    t1[6] = '{S_R, -3, 1, 1'b0};
    t1[7] = '{S_R, -2, 1, 1'b0};
    t1[8] = '{S_L, -3, 2, 1'b1};
    t1[9] = '{S_L, -4, 2, 1'b0};

    areset = 1'b1;
    model_reset();
    #12;
    compare_all();
    areset = 1'b0;

    // Walking with two reversals.
    tp_seen = 0;
    for (int i = 0; i < 10; i++) begin
      apply(t1[i].smp);
      check("t1_pos",   int'(pos),        t1[i].pos);
      check("t1_turns", int'(turn_count), t1[i].turns);
      check("t1_tp",    int'(turn_pulse), int'(t1[i].tp));
      if (turn_pulse) tp_seen++;
    end
    check("t1_tp_seen", tp_seen, 2);
    check("t1_fault",   int'(fault), 0);

    // Walk, fall 7, land in the same direction.
    do_reset();
    apply_n(S_L, 2);
    apply_n(S_F, 7);
    apply(S_L);
    check("t2_land",     int'(land_pulse), 1);
    check("t2_fall_len", int'(fall_len),   7);
    check("t2_max_fall", int'(max_fall),   7);
    check("t2_pos",      int'(pos),        -3);
    check("t2_turns",    int'(turn_count), 0);
    apply(S_L);
    check("t2_land_off", int'(land_pulse), 0);

    // Two landings; the shorter latest fall must not lower max_fall.
    do_reset();
    apply(S_L); apply_n(S_F, 4); apply(S_L);
    apply_n(S_F, 9); apply(S_R);
    check("t3_land_turn", int'(turn_pulse), 1);
    apply_n(S_F, 3); apply(S_R);
    check("t3_fall_len", int'(fall_len),   3);
    check("t3_max_fall", int'(max_fall),   9);
    check("t3_turns",    int'(turn_count), 1);
    // net steps: L, L(landing), R(landing), R(landing)
    check("t3_pos",      int'(pos),        0);

    // Splat: fall ends with nothing asserted; the lemming then stays frozen.
    do_reset();
    apply(S_L); apply_n(S_F, 25);
    apply(S_Z);
    check("t4_splat",    int'(splat_pulse), 1);
    check("t4_fall_len", int'(fall_len),    25);
    check("t4_max_fall", int'(max_fall),    0);
    check("t4_dead",     int'(dead),        1);
    apply(S_L); apply(S_R); apply(S_F);
    check("t4_pos_frozen", int'(pos),         -1);
    check("t4_splat_once", int'(splat_pulse), 0);
    check("t4_still_dead", int'(dead),        1);

    // Dig then walk out is a fault; reset clears everything.
    do_reset();
    apply(S_L); apply_n(S_D, 4); apply(S_R);
    check("t5_digs",  int'(dig_cycles), 4);
    check("t5_fault", int'(fault),      1);
    check("t5_dead",  int'(dead),       0);
    check("t5_pos",   int'(pos),        -1);
    do_reset();
    check("t5_rst_fault", int'(fault),      0);
    check("t5_rst_digs",  int'(dig_cycles), 0);
    check("t5_rst_pos",   int'(pos),        0);

    // Reset in the middle of a fall: the partial fall is never recorded.
    apply(S_L); apply_n(S_F, 5);
    do_reset();
    apply(S_L); apply_n(S_F, 2);
    land_seen = 0;
    apply(S_L);
    if (land_pulse) land_seen++;
    check("t5b_land",     land_seen,       1);
    check("t5b_fall_len", int'(fall_len),  2);
    check("t5b_max_fall", int'(max_fall),  2);

    // Position and fall-counter saturation.
    do_reset();
    apply_n(S_R, 130);
    check("t6_pos_hi", int'(pos), POS_HI);
    apply_n(S_F, 300);
    apply(S_L);
    check("t6_fall_len", int'(fall_len), CNT_MAX);
    check("t6_max_fall", int'(max_fall), CNT_MAX);
    do_reset();
    apply_n(S_L, 130);
    check("t6_pos_lo", int'(pos), POS_LO);

    // Randomized episodes against the reference model.
    for (int ep = 0; ep < 40; ep++) begin
      do_reset();
      prev_s = S_L;
      for (int c = 0; c < 120; c++) begin
        prev_s = rand_sample(prev_s);
        apply(prev_s);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
